// File: rtl/clint_timer_if.sv
// Bus port bundle for the machine timer block.
// Handshake: the master raises i_req for exactly one cycle per access (no
// back-pressure, every request is accepted); the slave answers with a one-cycle
// o_rvalid pulse exactly one clock later, carrying o_rdata and o_err.
interface clint_timer_if;
  logic        i_req;
  logic        i_we;
  logic [4:0]  i_addr;
  logic [3:0]  i_be;
  logic [31:0] i_wdata;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_err;

  modport master (
    output i_req, i_we, i_addr, i_be, i_wdata,
    input  o_rvalid, o_rdata, o_err
  );

  modport slave (
    input  i_req, i_we, i_addr, i_be, i_wdata,
    output o_rvalid, o_rdata, o_err
  );
endinterface

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime with a programmable prescaler, 64-bit mtimecmp,
// registered interrupt level o_mtip, and a hi-half snapshot so software can
// read mtime as lo-then-hi without tearing.
module clint_timer #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned RST_DIV = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  clint_timer_if.slave  bus,
  output logic          o_mtip
);

  localparam logic [2:0] W_MTIME_LO = 3'd0;
  localparam logic [2:0] W_MTIME_HI = 3'd1;
  localparam logic [2:0] W_CMP_LO   = 3'd2;
  localparam logic [2:0] W_CMP_HI   = 3'd3;
  localparam logic [2:0] W_CTRL     = 3'd4;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [31:0]      hi_snap_q, hi_snap_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             rvalid_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             mtip_q;

  logic             addr_ok;
  logic [2:0]       word;
  logic             wr, rd;
  logic             tick;
  logic [DIV_W:0]   ctrl_old;
  logic [DIV_W:0]   ctrl_wr;
  logic [31:0]      ctrl_rd;

  // Byte-lane merge: lanes with a clear enable keep their old value.
  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  assign addr_ok = (bus.i_addr[1:0] == 2'b00) && (bus.i_addr <= 5'h10);
  assign word    = bus.i_addr[4:2];
  assign wr      = bus.i_req && bus.i_we && addr_ok;
  assign rd      = bus.i_req && !bus.i_we && addr_ok;
  assign tick    = en_q && (cnt_q == div_q);
  assign ctrl_old = {div_q, en_q};
  assign ctrl_rd  = {{(31 - DIV_W){1'b0}}, div_q, en_q};

  // Per-bit byte-lane merge of the ctrl fields; bits above DIV are not stored.
  always_comb begin
    ctrl_wr = ctrl_old;
    for (int i = 0; i <= int'(DIV_W); i++) begin
      ctrl_wr[i] = bus.i_be[i / 8] ? bus.i_wdata[i] : ctrl_old[i];
    end
  end

  // Next-state for counter, compare, snapshot and ctrl; bus writes win over ticks.
  always_comb begin
    mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
    mtimecmp_d = mtimecmp_q;
    hi_snap_d  = hi_snap_q;
    en_d       = en_q;
    div_d      = div_q;
    cnt_d      = en_q ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;

    if (wr) begin
      case (word)
        W_MTIME_LO: mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], bus.i_wdata, bus.i_be)};
        W_MTIME_HI: begin
          mtime_d   = {merge_be(mtime_q[63:32], bus.i_wdata, bus.i_be), mtime_q[31:0]};
          hi_snap_d = merge_be(mtime_q[63:32], bus.i_wdata, bus.i_be);
        end
        W_CMP_LO: mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0], bus.i_wdata, bus.i_be);
        W_CMP_HI: mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], bus.i_wdata, bus.i_be);
        W_CTRL: begin
          en_d  = ctrl_wr[0];
          div_d = ctrl_wr[DIV_W:1];
          cnt_d = '0;
        end
        default: ;
      endcase
    end else if (rd && (word == W_MTIME_LO)) begin
      hi_snap_d = mtime_q[63:32];
    end
  end

  // Read mux samples pre-update values; errors and writes return zero.
  always_comb begin
    rdata_d = 32'd0;
    err_d   = bus.i_req && !addr_ok;
    if (rd) begin
      case (word)
        W_MTIME_LO: rdata_d = mtime_q[31:0];
        W_MTIME_HI: rdata_d = hi_snap_q;
        W_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        W_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        W_CTRL:     rdata_d = ctrl_rd;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  // Register all state and the bus response; a request during reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      hi_snap_q  <= 32'd0;
      en_q       <= 1'b1;
      div_q      <= DIV_W'(RST_DIV);
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      hi_snap_q  <= hi_snap_d;
      en_q       <= en_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= bus.i_req;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mtip_q     <= (mtime_d >= mtimecmp_d);
    end
  end

  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_err    = err_q;
  assign o_mtip       = mtip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed sequences plus random traffic, with a
// reference model of the timer and a response scoreboard.
module tb_clint_timer;

  logic i_clk;
  logic i_rst;
  logic o_mtip;

  clint_timer_if bus();

  clint_timer #(.DIV_W(16), .RST_DIV(0)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus),
    .o_mtip(o_mtip)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scoreboard queues: {err, rdata} and the cycle at which it must show up
  logic [32:0] exp_q[$];
  int          due_q[$];
  bit          mon_en = 0;
  bit          chk_no_rv = 0;

  // Reference model state
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_snap;
  logic        m_en;
  logic [15:0] m_div, m_cnt;
  logic        m_mtip;

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic bit m_ok(input logic [4:0] a);
    return (a % 4 == 0) && (a <= 16);
  endfunction

  function automatic logic [32:0] m_resp(input logic w, input logic [4:0] a);
    if (!m_ok(a)) return {1'b1, 32'd0};
    if (w) return 33'd0;
    case (a)
      5'd0:    return {1'b0, m_mtime[31:0]};
      5'd4:    return {1'b0, m_snap};
      5'd8:    return {1'b0, m_cmp[31:0]};
      5'd12:   return {1'b0, m_cmp[63:32]};
      default: return {1'b0, 15'd0, m_div, m_en};
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = '1; m_snap = 32'd0;
    m_en = 1'b1; m_div = 16'd0; m_cnt = 16'd0; m_mtip = 1'b0;
  endtask

  task automatic model_step(input logic rq, input logic w, input logic [4:0] a,
                            input logic [3:0] be, input logic [31:0] d);
    logic [63:0] nt;
    logic [15:0] nc;
    logic [31:0] cw;
    bit tick;
    tick = m_en && (m_cnt == m_div);
    nt = tick ? m_mtime + 64'd1 : m_mtime;
    nc = !m_en ? m_cnt : (tick ? 16'd0 : m_cnt + 16'd1);
    if (rq && m_ok(a) && w) begin
      case (a)
        5'd0:  nt = {m_mtime[63:32], m_merge(m_mtime[31:0], d, be)};
        5'd4:  begin
          nt = {m_merge(m_mtime[63:32], d, be), m_mtime[31:0]};
          m_snap = nt[63:32];
        end
        5'd8:  m_cmp[31:0]  = m_merge(m_cmp[31:0], d, be);
        5'd12: m_cmp[63:32] = m_merge(m_cmp[63:32], d, be);
        default: begin
          cw = m_merge({15'd0, m_div, m_en}, d, be);
          m_en = cw[0]; m_div = cw[16:1]; nc = 16'd0;
        end
      endcase
    end else if (rq && m_ok(a) && !w && a == 5'd0) begin
      m_snap = m_mtime[63:32];
    end
    m_mtime = nt;
    m_cnt = nc;
    m_mtip = (m_mtime >= m_cmp);
  endtask

  // Driver tasks
  task automatic cycle(input logic rq, input logic w, input logic [4:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    @(negedge i_clk);
    i_rst = 1'b0;
    bus.i_req = rq; bus.i_we = w; bus.i_addr = a; bus.i_be = be; bus.i_wdata = d;
    if (rq) begin
      exp_q.push_back(m_resp(w, a));
      due_q.push_back(cyc + 1);
    end
    @(posedge i_clk);
    model_step(rq, w, a, be, d);
  endtask

  task automatic reset_cycle(input logic rq);
    @(negedge i_clk);
    i_rst = 1'b1;
    bus.i_req = rq; bus.i_we = 1'b0; bus.i_addr = 5'd0; bus.i_be = 4'hF; bus.i_wdata = 32'd0;
    @(posedge i_clk);
    model_reset();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, 4'hF, d);
  endtask

  task automatic rd(input logic [4:0] a);
    cycle(1'b1, 1'b0, a, 4'h0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'd0);
  endtask

  // Monitor / scoreboard: interrupt level every cycle, responses as they appear
  always @(negedge i_clk) begin
    if (mon_en) begin
      logic [32:0] e;
      int du;
      tests++;
      if (o_mtip !== m_mtip) begin
        fails++;
        $display("FAIL mtip cyc=%0d got=%b exp=%b", cyc, o_mtip, m_mtip);
      end
      if (chk_no_rv) begin
        chk_no_rv = 0;
        tests++;
        if (bus.o_rvalid !== 1'b0) begin
          fails++;
          $display("FAIL rst_drop cyc=%0d got rvalid=%b exp=0", cyc, bus.o_rvalid);
        end
      end
      if (bus.o_rvalid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rvalid cyc=%0d got=1 exp=0", cyc);
        end else begin
          e = exp_q.pop_front();
          du = due_q.pop_front();
          if (bus.o_rdata !== e[31:0] || bus.o_err !== e[32] || du != cyc) begin
            fails++;
            $display("FAIL resp cyc=%0d got data=%h err=%b exp data=%h err=%b due=%0d",
                     cyc, bus.o_rdata, bus.o_err, e[31:0], e[32], du);
          end
        end
      end else if (exp_q.size() > 0 && due_q[0] <= cyc) begin
        tests++;
        fails++;
        e = exp_q.pop_front();
        du = due_q.pop_front();
        $display("FAIL missing_rvalid cyc=%0d got=%b exp=1 due=%0d", cyc, bus.o_rvalid, du);
      end
    end
  end

  // Global time limit
  initial begin
    #1000000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [4:0] addr_tab [9];
    logic [4:0] a;
    logic [31:0] d;
    addr_tab = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd2, 5'd28, 5'd16};

    i_rst = 1'b1;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 5'd0; bus.i_be = 4'h0; bus.i_wdata = 32'd0;
    model_reset();
    reset_cycle(1'b0);
    reset_cycle(1'b0);
    mon_en = 1;

    // Free-running at DIV=0, reset values of mtimecmp and ctrl
    rd(5'd0);
    idle(9);
    rd(5'd0);
    rd(5'd8);
    rd(5'd12);
    rd(5'd16);

    // DIV=3 then EN=0 freeze
    wr(5'd16, (32'd3 << 1) | 32'd1);
    rd(5'd0);
    idle(40);
    rd(5'd0);
    wr(5'd16, 32'd0);
    rd(5'd0);
    idle(20);
    rd(5'd0);

    // Carry from lo into hi
    wr(5'd0, 32'hFFFF_FFFE);
    wr(5'd4, 32'd0);
    wr(5'd16, 32'd1);
    idle(3);
    rd(5'd0);
    rd(5'd4);

    // Snapshot: hi read returns value captured by the lo read
    wr(5'd16, 32'd0);
    wr(5'd4, 32'd0);
    wr(5'd0, 32'hFFFF_FFFF);
    wr(5'd16, 32'd1);
    rd(5'd0);
    idle(5);
    rd(5'd4);

    // Compare: interrupt rises at 100, falls after raising mtimecmp
    wr(5'd12, 32'd0);
    wr(5'd8, 32'd100);
    wr(5'd4, 32'd0);
    wr(5'd0, 32'd95);
    idle(10);
    wr(5'd8, 32'd1000);
    idle(3);

    // Partial byte write while ticking
    wr(5'd0, 32'hAABB_CCDD);
    cycle(1'b1, 1'b1, 5'd0, 4'b0011, 32'h1234_5678);
    rd(5'd0);
    rd(5'd4);

    // Errors and back-to-back requests
    rd(5'd20);
    rd(5'd2);
    cycle(1'b1, 1'b1, 5'd6, 4'hF, 32'hDEAD_BEEF);
    rd(5'd8);
    rd(5'd12);
    rd(5'd16);
    idle(2);

    // Request during reset is dropped
    reset_cycle(1'b1);
    chk_no_rv = 1;
    idle(2);
    rd(5'd8);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        a = addr_tab[$urandom_range(0, 8)];
        case (a)
          5'd16:        d = ($urandom_range(0, 5) << 1) | 32'($urandom_range(0, 3) != 0);
          5'd4, 5'd12:  d = $urandom_range(0, 1);
          5'd0, 5'd8:   d = $urandom_range(0, 300);
          default:      d = $urandom;
        endcase
        cycle(1'b1, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d);
      end else begin
        idle(1);
      end
    end

    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Machine-level timer: 64-bit mtime counter, 64-bit mtimecmp compare register, memory-mapped on the 32-bit data bus.
- Produces the registered timer-interrupt level o_mtip.
- o_mtip drives the CSR file's i_mtip input, which mirrors it into mip.MTIP.
- Includes a programmable prescaler and a read-snapshot of mtime_hi for tear-free 64-bit reads.

Parameters:
- DIV_W, 16, width of the prescaler divider field and counter.
- RST_DIV, 0, reset value of the divider; the tick period is DIV+1 clocks.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  1  bus request, one-cycle pulse per access
- i_we  in  1  1 = write, 0 = read
- i_addr  in  5  byte offset within timer block
- i_be  in  4  byte enables for writes
- i_wdata  in  32  write data
- o_rvalid  out  1  response valid, exactly one cycle after each i_req
- o_rdata  out  32  read data, valid with o_rvalid, 0 for writes and errors
- o_err  out  1  access error, valid with o_rvalid
- o_mtip  out  1  machine timer interrupt pending level

Behaviour:
- Register map (word offsets):
  - 0x00 mtime_lo
  - 0x04 mtime_hi
  - 0x08 mtimecmp_lo
  - 0x0C mtimecmp_hi
  - 0x10 ctrl: bit0 EN; bits[DIV_W:1] DIV; other bits read 0 and ignore writes.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; EN = 1; DIV = RST_DIV.
  - Prescaler count = 0; hi_snap = 0.
  - o_mtip = 0, o_rvalid = 0, o_rdata = 0, o_err = 0.
- Bus protocol:
  - Every i_req is accepted; there is no back-pressure.
  - The response (o_rvalid = 1) is registered and appears exactly one cycle later.
  - Back-to-back requests on consecutive cycles are legal; each gets its own response.
- Errors:
  - o_err = 1 if i_addr[1:0] != 0 or the offset is unmapped (> 0x10).
  - An errored access has no side effects; o_rdata = 0.
- Writes are byte-granular per i_be; lanes with i_be = 0 are unchanged.
- Prescaler:
  - When EN = 1, the count increments each clock.
  - When count == DIV, the count returns to 0 and a tick is generated; mtime += 1 on the tick (64-bit wrap from all-ones to 0).
  - When EN = 0, the count and mtime hold. Clearing EN also resets the count to 0.
  - A write to ctrl resets the count to 0.
- Bus write vs. tick in the same cycle: on a write to mtime_lo or mtime_hi, the written half takes the written value and no increment is applied that cycle. The other half holds, with no carry.
- Snapshot reads:
  - A read of mtime_lo returns the current mtime[31:0] and captures mtime[63:32] into hi_snap in the same cycle.
  - A read of mtime_hi returns hi_snap, not the live value.
  - hi_snap is also loaded by any write to mtime_hi (with the new value).
- Read data is sampled at the request cycle (pre-update values).
- mtimecmp halves are written independently; there is no atomic 64-bit update.
- o_mtip is registered: o_mtip <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare.
  - It updates the cycle after any change to mtime or mtimecmp.
  - It is a level, cleared only by raising mtimecmp or lowering mtime.
- Reset mid-access: a request in the reset cycle is dropped; no response is generated.
- Block size: about 150-250 lines of RTL.

Test Plan:
- Reset, then DIV = 0: read mtime_lo at cycles 0 and 10 after reset -> the values differ by 10; o_mtip = 0; mtimecmp reads 0xFFFFFFFF in both halves.
- Write ctrl = (3<<1)|1 (DIV = 3), wait 40 cycles -> mtime advances by 10 ±1.
- Write EN = 0 -> mtime frozen across 20 cycles.
- Write mtime_lo = 0xFFFFFFFE, mtime_hi = 0, DIV = 0; wait 3 cycles; read lo then hi -> hi = 1, lo = 1 (carry into hi).
- Read lo returning 0xFFFFFFFF, then read hi 5 cycles later -> hi returns the snapshot 0, not the live 1.
- mtimecmp = 100, mtime = 95, DIV = 0 -> o_mtip rises the cycle after mtime reaches 100.
- Then write mtimecmp_lo = 1000 -> o_mtip falls exactly one cycle after the write.
- Write mtime_lo = 0x12345678 with i_be = 4'b0011 while ticking -> the low 16 bits = 0x5678, upper bytes unchanged, no increment that cycle.
- Read 0x14 -> o_err = 1, o_rdata = 0.
- Read 0x02 -> o_err = 1.
- Three consecutive reqs -> three consecutive o_rvalid pulses.
